// File: rtl/gpu_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : gpu_fifo_pkg                                                 |
// | Description : Shared constants and types for the GPU clock-crossing FIFO   |
// |               read/write side adapters (word buffer depth, pointer and     |
// |               count types, pointer wrap helper).                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package gpu_fifo_pkg;

    localparam int UNPACK_BUF_DEPTH = 3;

    typedef logic [1:0] buf_ptr_t;  // index into the word buffer
    typedef logic [1:0] buf_cnt_t;  // words held, 0..UNPACK_BUF_DEPTH

    // Circular increment; depth is not a power of two so wrap explicitly.
    function automatic buf_ptr_t buf_ptr_next(input buf_ptr_t p);
        return (p == buf_ptr_t'(UNPACK_BUF_DEPTH - 1)) ? buf_ptr_t'(0) : buf_ptr_t'(p + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_stream_unpacker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : fifo_stream_unpacker_if                                      |
// | Description : FIFO read port plus valid/ready output stream of the         |
// |               unpacker. master = unpacker side, slave = FIFO + sink side.  |
// |   fifo_rd_en_o   : read strobe towards the FIFO                            |
// |   fifo_empty_i   : FIFO empty flag                                         |
// |   fifo_rd_data_i : FIFO read data, valid the cycle after the strobe        |
// |   m_valid_o / m_ready_i / m_data_o / m_last_o : output beat stream         |
// |   occ_o          : words held in the unpacker buffer (status)              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fifo_stream_unpacker_if
    import gpu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 16
);
    logic                  fifo_rd_en_o;
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [OUT_WIDTH-1:0]  m_data_o;
    logic                  m_last_o;
    buf_cnt_t              occ_o;

    modport master (
        output fifo_rd_en_o,
        input  fifo_empty_i,
        input  fifo_rd_data_i,
        output m_valid_o,
        input  m_ready_i,
        output m_data_o,
        output m_last_o,
        output occ_o
    );

    modport slave (
        input  fifo_rd_en_o,
        output fifo_empty_i,
        output fifo_rd_data_i,
        input  m_valid_o,
        output m_ready_i,
        input  m_data_o,
        input  m_last_o,
        input  occ_o
    );
endinterface
`default_nettype wire

// File: rtl/word_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_skid_buf                                                |
// | Description : 3-entry circular register FIFO, single clock, sync reset.    |
// |   clk_i, rst_i  : clock, synchronous active-high reset                     |
// |   push_i        : write push_data_i at tail                                |
// |   pop_i         : drop head word (ignored when empty)                      |
// |   head_data_o   : word at head (storage resets to zero)                    |
// |   count_o       : words held, 0..3                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module word_skid_buf
    import gpu_fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output      logic [WIDTH-1:0] head_data_o,
    output      buf_cnt_t         count_o
);

    logic [WIDTH-1:0] r_mem [UNPACK_BUF_DEPTH];
    buf_ptr_t         r_head;
    buf_ptr_t         r_tail;
    buf_cnt_t         r_count;
    logic             w_pop;

    assign w_pop       = pop_i && (r_count != '0);
    assign head_data_o = r_mem[r_head];
    assign count_o     = r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < UNPACK_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_tail] <= push_data_i;
                r_tail        <= buf_ptr_next(r_tail);
            end
            if (w_pop) begin
                r_head <= buf_ptr_next(r_head);
            end
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream credit accounting must never offer a word into a full buffer.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && !w_pop && r_count == buf_cnt_t'(UNPACK_BUF_DEPTH)))
                else $error("word_skid_buf overflow");
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_stream_unpacker                                         |
// | Description : Drains a FIFO read port (data one cycle after strobe) into a |
// |               valid/ready stream, splitting each word into                 |
// |               DATA_WIDTH/OUT_WIDTH beats, least significant slice first.   |
// |   clk_i : FIFO read clock                                                  |
// |   rst_i : synchronous active-high reset                                    |
// |   bus   : FIFO read port + output stream + occupancy (master modport)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_stream_unpacker
    import gpu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 16
) (
    input wire logic              clk_i,
    input wire logic              rst_i,
    fifo_stream_unpacker_if.master bus
);

    localparam int c_ratio = DATA_WIDTH / OUT_WIDTH;
    localparam int c_sub_w = (c_ratio > 1) ? $clog2(c_ratio) : 1;

    generate
        if (c_ratio < 1 || (c_ratio & (c_ratio - 1)) != 0 || c_ratio * OUT_WIDTH != DATA_WIDTH) begin : g_bad_ratio
            $error("fifo_stream_unpacker: DATA_WIDTH/OUT_WIDTH must be a power of two >= 1");
        end
    endgenerate

    logic                  r_inflight;
    buf_cnt_t              w_count;
    logic [2:0]            w_credit;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_valid;
    logic                  w_accept;
    logic                  w_last_slice;
    logic                  w_pop;
    logic [OUT_WIDTH-1:0]  w_slice;

    // A read is only issued when the word it returns is guaranteed a slot:
    // held words plus the one already in flight must leave room.
    assign w_credit = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_rd_en  = !rst_i && !bus.fifo_empty_i && (w_credit < 3'(UNPACK_BUF_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    assign w_valid  = (w_count != '0);
    assign w_accept = w_valid && bus.m_ready_i;
    assign w_pop    = w_accept && w_last_slice;

    // The buffer's own reset takes priority over push, so a word returning
    // from a read issued just before reset is dropped.
    word_skid_buf #(
        .WIDTH       (DATA_WIDTH)
    ) u_word_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (r_inflight),
        .push_data_i (bus.fifo_rd_data_i),
        .pop_i       (w_pop),
        .head_data_o (w_head),
        .count_o     (w_count)
    );

    generate
        if (c_ratio > 1) begin : g_sub
            logic [c_sub_w-1:0] r_sub;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_sub <= '0;
                end else if (w_accept) begin
                    r_sub <= w_last_slice ? '0 : r_sub + 1'b1;
                end
            end

            assign w_last_slice = (r_sub == c_sub_w'(c_ratio - 1));
            assign w_slice      = w_head[r_sub * OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_no_sub
            assign w_last_slice = 1'b1;
            assign w_slice      = w_head[OUT_WIDTH-1:0];
        end
    endgenerate

    assign bus.fifo_rd_en_o = w_rd_en;
    assign bus.m_valid_o    = w_valid;
    assign bus.m_data_o     = w_slice;
    assign bus.m_last_o     = w_valid && w_last_slice;
    assign bus.occ_o        = w_count;

endmodule
`default_nettype wire
